fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, byte address of first fetch (word aligned).
REQ-002 SHALL provide parameter LOAD_CYCLES, default 2, number of cycles startin is held high after reset (legal range 1..255).
REQ-003 SHALL provide parameter PROG_END, default 32'd80, first byte address past the program; fetch stops on reaching it.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port startin  output  1  instruction-memory preload enable; high only in LOAD.
REQ-007 SHALL have port pc  output  32  byte fetch address driven to instruction memory.
REQ-008 SHALL have port instr_in  input  32  instruction word returned combinationally by memory for pc.
REQ-009 SHALL have port stall  input  1  freeze request from downstream.
REQ-010 SHALL have port branch_taken  input  1  redirect request from decode of instr_out.
REQ-011 SHALL have port branch_offset  input  32  sign-extended word offset of the branch.
REQ-012 SHALL have port jump  input  1  jump request from decode of instr_out.
REQ-013 SHALL have port jump_index  input  26  jump target word index.
REQ-014 SHALL have port instr_out  output  32  registered instruction (IF/ID register).
REQ-015 SHALL have port pc_plus4  output  32  registered address of instr_out plus 4.
REQ-016 SHALL have port instr_valid  output  1  instr_out holds a live instruction.
REQ-017 SHALL have port halted  output  1  fetch has stopped at PROG_END.

Function
REQ-018 SHALL implement FSM states LOAD, RUN, HALT; all outputs registered except startin, which decodes state==LOAD.
REQ-019 LOAD: pc held at RESET_PC, instr_valid=0; a cycle counter moves the FSM to RUN after exactly LOAD_CYCLES cycles.
REQ-020 RUN priority per cycle SHALL be: stall > jump > branch_taken > end check > sequential fetch.
REQ-021 stall=1: pc, instr_out, pc_plus4, instr_valid all hold; jump/branch_taken ignored that cycle (requester holds them).
REQ-022 jump=1 with instr_valid=1: pc <= {pc_plus4[31:28], jump_index, 2'b00}; instr_valid <= 0 (wrong-path fetch squashed).
REQ-023 branch_taken=1 with instr_valid=1, jump=0: pc <= pc_plus4 + (branch_offset << 2), modulo 2^32; instr_valid <= 0.
REQ-024 jump/branch_taken with instr_valid=0 SHALL be ignored.
REQ-025 No redirect and pc >= PROG_END: FSM -> HALT, instr_valid <= 0, pc held.
REQ-026 Sequential fetch: instr_out <= instr_in; pc_plus4 <= pc + 4; pc <= pc + 4 (wraps at 2^32); instr_valid <= 1.
REQ-027 Redirect whose target >= PROG_END SHALL be taken; halt occurs on the following non-stalled cycle.
REQ-028 HALT: sticky until reset; halted=1, instr_valid=0, pc and instr_out hold; stall, jump, branch inputs ignored.
REQ-029 Single-cycle fetch latency: word at pc appears on instr_out one edge after it is addressed.

Reset
REQ-030 reset=1 at an edge SHALL, from any state including mid-RUN or HALT, set state=LOAD, counter=0, pc=RESET_PC, instr_out=0, pc_plus4=0, instr_valid=0, halted=0; startin=1 from the next cycle.
REQ-031 reset SHALL take priority over stall and all redirect inputs.

Verification
REQ-032 Reset, LOAD_CYCLES=2 -> startin=1 for exactly 2 cycles, pc=0; next edge instr_out=instr_in@0, pc_plus4=4, pc=4, instr_valid=1.
REQ-033 Free-run 20 words, PROG_END=80 -> pc reaches 80, next edge halted=1, instr_valid=0, pc stays 80 indefinitely.
REQ-034 stall=1 for 3 cycles with pc=8 -> pc=8, instr_out, instr_valid unchanged; fetch resumes at 8 after release.
REQ-035 instr_valid=1, pc_plus4=0x0C, branch_taken=1, branch_offset=0xFFFF_FFFE -> pc=0x04, instr_valid=0; next edge fetches 0x04; jump=1 simultaneous wins.
REQ-036 instr_valid=1, jump=1, jump_index=26'h10, pc_plus4=0x10 -> pc=0x40, instr_valid=0; jump with instr_valid=0 -> ignored.
REQ-037 reset asserted in RUN at pc=0x24 -> next cycle pc=0, startin=1, instr_valid=0, halted=0; normal sequence repeats.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage with an IF/ID pipeline register.  After reset the
// unit sits in LOAD for LOAD_CYCLES cycles with startin raised so the
// instruction memory can be preloaded.  It then fetches sequentially from
// RESET_PC, honouring stall, jump and taken-branch requests from decode.
// It stops for good in HALT once the fetch address reaches PROG_END.
//
// Parameters
//   RESET_PC     byte address of the first fetch (word aligned)
//   LOAD_CYCLES  number of cycles startin stays high after reset (1..255)
//   PROG_END     first byte address past the program
//
// Ports
//   clk            in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   startin        out  memory preload enable, high only in LOAD
//   pc             out  byte fetch address to instruction memory
//   instr_in       in   instruction word returned combinationally for pc
//   stall          in   freeze request from downstream
//   branch_taken   in   redirect request from decode of instr_out
//   branch_offset  in   sign-extended word offset of the branch
//   jump           in   jump request from decode of instr_out
//   jump_index     in   jump target word index
//   instr_out      out  registered instruction (IF/ID register)
//   pc_plus4       out  registered address of instr_out plus 4
//   instr_valid    out  instr_out holds a live instruction
//   halted         out  fetch has stopped at PROG_END
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          LOAD_CYCLES = 2,
    parameter logic [31:0] PROG_END    = 32'd80
) (
    input  logic        clk,
    input  logic        reset,
    output logic        startin,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // The load counter runs from 0 up to LOAD_CYCLES-1; the cycle on which
    // it reaches that value is the last LOAD cycle.
    localparam logic [7:0] LOAD_LAST = 8'(LOAD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  load_cnt, load_cnt_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc_plus4_nxt;
    logic        valid_nxt;
    logic        halted_nxt;

    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // Redirect targets are formed from pc_plus4, i.e. relative to the
    // instruction currently sitting in the IF/ID register, not to pc.
    always_comb begin
        jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
        branch_target = pc_plus4 + (branch_offset << 2);
    end

    // startin is the only output decoded directly from state.
    always_comb begin
        startin = (state == LOAD);
    end

    // Next-state and next-register logic.  Everything holds by default, so
    // only the cases that actually change something are spelled out.  In
    // RUN the if/else chain encodes the priority stall > jump > branch >
    // end check > sequential fetch.  Redirects only count when instr_valid
    // is set, since decode of a squashed slot must not steer fetch.
    always_comb begin
        state_nxt    = state;
        load_cnt_nxt = load_cnt;
        pc_nxt       = pc;
        instr_nxt    = instr_out;
        pc_plus4_nxt = pc_plus4;
        valid_nxt    = instr_valid;
        halted_nxt   = halted;

        case (state)
            LOAD: begin
                valid_nxt = 1'b0;
                if (load_cnt == LOAD_LAST) begin
                    state_nxt    = RUN;
                    load_cnt_nxt = 8'd0;
                end else begin
                    load_cnt_nxt = load_cnt + 8'd1;
                end
            end

            RUN: begin
                if (stall) begin
                    // Freeze: the requester keeps jump/branch asserted
                    // until we are able to act on them.
                end else if (jump && instr_valid) begin
                    pc_nxt    = jump_target;
                    valid_nxt = 1'b0;
                end else if (branch_taken && instr_valid) begin
                    pc_nxt    = branch_target;
                    valid_nxt = 1'b0;
                end else if (pc >= PROG_END) begin
                    // A redirect past the program end lands here on the
                    // next non-stalled cycle, so it halts one cycle late.
                    state_nxt  = HALT;
                    valid_nxt  = 1'b0;
                    halted_nxt = 1'b1;
                end else begin
                    instr_nxt    = instr_in;
                    pc_plus4_nxt = pc + 32'd4;
                    pc_nxt       = pc + 32'd4;
                    valid_nxt    = 1'b1;
                end
            end

            HALT: begin
                valid_nxt  = 1'b0;
                halted_nxt = 1'b1;
            end

            default: begin
                // Unused encoding: fall back to a clean restart.
                state_nxt    = LOAD;
                load_cnt_nxt = 8'd0;
                pc_nxt       = RESET_PC;
                valid_nxt    = 1'b0;
                halted_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers.  Reset is synchronous and overrides every
    // other input, including stall and the redirect requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD;
            load_cnt    <= 8'd0;
            pc          <= RESET_PC;
            instr_out   <= 32'd0;
            pc_plus4    <= 32'd0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            load_cnt    <= load_cnt_nxt;
            pc          <= pc_nxt;
            instr_out   <= instr_nxt;
            pc_plus4    <= pc_plus4_nxt;
            instr_valid <= valid_nxt;
            halted      <= halted_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Testbench for fetch_unit with default parameters.  A 256-word instruction
// memory answers pc combinationally.  A cycle-level reference model written
// from the fetch rules predicts the outputs; directed scenarios plus a long
// randomized run are compared against it and against fixed expectations.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          LOAD_CYCLES = 2;
    localparam logic [31:0] PROG_END    = 32'd80;

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk;
    logic        reset;
    logic        startin;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;

    logic [31:0] mem [0:255];

    int total;
    int bad;

    // Reference model state
    int          mMode;
    int          mLoadLeft;
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mPp4;
    logic        mValid;
    logic        mHalted;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .LOAD_CYCLES(LOAD_CYCLES),
        .PROG_END   (PROG_END)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startin      (startin),
        .pc           (pc),
        .instr_in     (instr_in),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .instr_out    (instr_out),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    // Instruction memory returns the word at pc without delay.
    assign instr_in = mem[pc[9:2]];

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        if (reset) begin
            mMode     = M_LOAD;
            mLoadLeft = LOAD_CYCLES;
            mPc       = RESET_PC;
            mInstr    = 32'd0;
            mPp4      = 32'd0;
            mValid    = 1'b0;
            mHalted   = 1'b0;
        end else if (mMode == M_LOAD) begin
            mLoadLeft = mLoadLeft - 1;
            if (mLoadLeft == 0) mMode = M_RUN;
        end else if (mMode == M_RUN && !stall) begin
            if (jump && mValid) begin
                mPc    = {mPp4[31:28], jump_index, 2'b00};
                mValid = 1'b0;
            end else if (branch_taken && mValid) begin
                mPc    = mPp4 + branch_offset * 32'd4;
                mValid = 1'b0;
            end else if (mPc >= PROG_END) begin
                mMode   = M_HALT;
                mValid  = 1'b0;
                mHalted = 1'b1;
            end else begin
                mInstr = mem[mPc[9:2]];
                mPp4   = mPc + 32'd4;
                mPc    = mPc + 32'd4;
                mValid = 1'b1;
            end
        end
    endtask

    // One clock: update the model, then land 1 unit after the rising edge.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'd0;
        jump          = 1'b0;
        jump_index    = 26'd0;
    endtask

    task automatic applyStimulus();
        clearInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        $display("[TB] test_reset");
        applyStimulus();
        total++; if (startin !== 1'b1) begin bad++; $display("[TB] FAIL reset_startin: got %b expected 1", startin); end
        total++; if (pc !== RESET_PC) begin bad++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        total++; if (instr_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 0", instr_out); end
        total++; if (pc_plus4 !== 32'd0) begin bad++; $display("[TB] FAIL reset_pp4: got %h expected 0", pc_plus4); end
        n = 0;
        while (startin === 1'b1 && n < 10) begin
            total++; if (pc !== RESET_PC) begin bad++; $display("[TB] FAIL load_pc: got %h expected %h", pc, RESET_PC); end
            n++;
            tick();
        end
        total++; if (n != LOAD_CYCLES) begin bad++; $display("[TB] FAIL load_len: got %0d expected %0d", n, LOAD_CYCLES); end
        tick();
        total++; if (instr_out !== mem[0]) begin bad++; $display("[TB] FAIL first_instr: got %h expected %h", instr_out, mem[0]); end
        total++; if (pc_plus4 !== 32'd4) begin bad++; $display("[TB] FAIL first_pp4: got %h expected 4", pc_plus4); end
        total++; if (pc !== 32'd4) begin bad++; $display("[TB] FAIL first_pc: got %h expected 4", pc); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL first_valid: got %b expected 1", instr_valid); end
    endtask

    task automatic test_free_run();
        int n;
        $display("[TB] test_free_run");
        applyStimulus();
        n = 0;
        while (!mHalted && n < 100) begin
            tick();
            n++;
            total++; if (pc !== mPc) begin bad++; $display("[TB] FAIL run_pc: got %h expected %h", pc, mPc); end
            total++; if (instr_out !== mInstr) begin bad++; $display("[TB] FAIL run_instr: got %h expected %h", instr_out, mInstr); end
            total++; if (instr_valid !== mValid) begin bad++; $display("[TB] FAIL run_valid: got %b expected %b", instr_valid, mValid); end
            total++; if (halted !== mHalted) begin bad++; $display("[TB] FAIL run_halted: got %b expected %b", halted, mHalted); end
        end
        total++; if (!mHalted) begin bad++; $display("[TB] FAIL run_timeout: got %0d cycles expected halt", n); end
        for (int i = 0; i < 6; i++) begin
            stall        = 1'($urandom_range(0, 1));
            jump         = 1'($urandom_range(0, 1));
            jump_index   = 26'($urandom_range(0, 15));
            branch_taken = 1'($urandom_range(0, 1));
            branch_offset = 32'($urandom_range(0, 7));
            tick();
            total++; if (pc !== PROG_END) begin bad++; $display("[TB] FAIL halt_pc: got %h expected %h", pc, PROG_END); end
            total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_flag: got %b expected 1", halted); end
            total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_valid: got %b expected 0", instr_valid); end
            total++; if (startin !== 1'b0) begin bad++; $display("[TB] FAIL halt_startin: got %b expected 0", startin); end
        end
        clearInputs();
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] savedInstr;
        logic        savedValid;
        $display("[TB] test_stall");
        applyStimulus();
        n = 0;
        while (mPc != 32'd8 && n < 20) begin tick(); n++; end
        total++; if (pc !== 32'd8) begin bad++; $display("[TB] FAIL stall_setup: got %h expected 8", pc); end
        savedInstr = mem[1];
        savedValid = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc !== 32'd8) begin bad++; $display("[TB] FAIL stall_pc: got %h expected 8", pc); end
            total++; if (instr_out !== savedInstr) begin bad++; $display("[TB] FAIL stall_instr: got %h expected %h", instr_out, savedInstr); end
            total++; if (instr_valid !== savedValid) begin bad++; $display("[TB] FAIL stall_valid: got %b expected %b", instr_valid, savedValid); end
        end
        stall = 1'b0;
        tick();
        total++; if (instr_out !== mem[2]) begin bad++; $display("[TB] FAIL resume_instr: got %h expected %h", instr_out, mem[2]); end
        total++; if (pc !== 32'd12) begin bad++; $display("[TB] FAIL resume_pc: got %h expected c", pc); end
    endtask

    task automatic test_branch();
        int n;
        $display("[TB] test_branch");
        applyStimulus();
        n = 0;
        while (!(mPp4 == 32'h0C && mValid) && n < 20) begin tick(); n++; end
        total++; if (pc_plus4 !== 32'h0C) begin bad++; $display("[TB] FAIL br_setup: got %h expected c", pc_plus4); end
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        tick();
        clearInputs();
        total++; if (pc !== 32'h04) begin bad++; $display("[TB] FAIL br_pc: got %h expected 4", pc); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL br_valid: got %b expected 0", instr_valid); end
        tick();
        total++; if (instr_out !== mem[1]) begin bad++; $display("[TB] FAIL br_fetch: got %h expected %h", instr_out, mem[1]); end
        total++; if (pc !== 32'h08) begin bad++; $display("[TB] FAIL br_next_pc: got %h expected 8", pc); end
        // Jump and branch together: jump must win.
        jump          = 1'b1;
        jump_index    = 26'h10;
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        tick();
        clearInputs();
        total++; if (pc !== 32'h40) begin bad++; $display("[TB] FAIL jb_pc: got %h expected 40", pc); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL jb_valid: got %b expected 0", instr_valid); end
    endtask

    task automatic test_jump();
        int n;
        $display("[TB] test_jump");
        applyStimulus();
        n = 0;
        while (!(mPp4 == 32'h10 && mValid) && n < 20) begin tick(); n++; end
        total++; if (pc_plus4 !== 32'h10) begin bad++; $display("[TB] FAIL jmp_setup: got %h expected 10", pc_plus4); end
        jump       = 1'b1;
        jump_index = 26'h10;
        tick();
        total++; if (pc !== 32'h40) begin bad++; $display("[TB] FAIL jmp_pc: got %h expected 40", pc); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL jmp_valid: got %b expected 0", instr_valid); end
        // Still requesting a jump, but the slot is invalid: must be ignored.
        jump_index = 26'h05;
        tick();
        clearInputs();
        total++; if (pc !== 32'h44) begin bad++; $display("[TB] FAIL jmp_ignore_pc: got %h expected 44", pc); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL jmp_ignore_valid: got %b expected 1", instr_valid); end
        total++; if (instr_out !== mem[16]) begin bad++; $display("[TB] FAIL jmp_ignore_instr: got %h expected %h", instr_out, mem[16]); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        $display("[TB] test_reset_mid_run");
        applyStimulus();
        n = 0;
        while (mPc != 32'h24 && n < 30) begin tick(); n++; end
        total++; if (pc !== 32'h24) begin bad++; $display("[TB] FAIL mid_setup: got %h expected 24", pc); end
        stall = 1'b1;
        jump  = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clearInputs();
        total++; if (pc !== RESET_PC) begin bad++; $display("[TB] FAIL mid_pc: got %h expected %h", pc, RESET_PC); end
        total++; if (startin !== 1'b1) begin bad++; $display("[TB] FAIL mid_startin: got %b expected 1", startin); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid: got %b expected 0", instr_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL mid_halted: got %b expected 0", halted); end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (pc !== mPc) begin bad++; $display("[TB] FAIL mid_seq_pc: got %h expected %h", pc, mPc); end
            total++; if (instr_out !== mInstr) begin bad++; $display("[TB] FAIL mid_seq_instr: got %h expected %h", instr_out, mInstr); end
            total++; if (startin !== (mMode == M_LOAD)) begin bad++; $display("[TB] FAIL mid_seq_startin: got %b expected %b", startin, (mMode == M_LOAD)); end
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        applyStimulus();
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            jump_index    = 26'($urandom_range(0, 24));
            branch_taken  = ($urandom_range(0, 7) == 0);
            branch_offset = 32'($urandom_range(0, 16)) - 32'd8;
            tick();
            total++; if (pc !== mPc) begin bad++; $display("[TB] FAIL rnd_pc: cycle %0d got %h expected %h", i, pc, mPc); end
            total++; if (instr_out !== mInstr) begin bad++; $display("[TB] FAIL rnd_instr: cycle %0d got %h expected %h", i, instr_out, mInstr); end
            total++; if (pc_plus4 !== mPp4) begin bad++; $display("[TB] FAIL rnd_pp4: cycle %0d got %h expected %h", i, pc_plus4, mPp4); end
            total++; if (instr_valid !== mValid) begin bad++; $display("[TB] FAIL rnd_valid: cycle %0d got %b expected %b", i, instr_valid, mValid); end
            total++; if (halted !== mHalted) begin bad++; $display("[TB] FAIL rnd_halted: cycle %0d got %b expected %b", i, halted, mHalted); end
            total++; if (startin !== (mMode == M_LOAD)) begin bad++; $display("[TB] FAIL rnd_startin: cycle %0d got %b expected %b", i, startin, (mMode == M_LOAD)); end
        end
        reset = 1'b0;
        clearInputs();
    endtask

    // Main sequence: fill memory, run every scenario, print the summary.
    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset = 1'b1;
        clearInputs();
        mMode     = M_LOAD;
        mLoadLeft = LOAD_CYCLES;
        mPc       = RESET_PC;
        mInstr    = 32'd0;
        mPp4      = 32'd0;
        mValid    = 1'b0;
        mHalted   = 1'b0;
        @(negedge clk);

        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_jump();
        test_reset_mid_run();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
